// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl
// Multiplexed N-digit 7-segment (FND) scan controller. Digits are scanned
// one slot at a time from a prescaled clock. New data is staged in a shadow
// register and only reaches the visible display register at a frame boundary,
// so a frame never mixes old and new digits. Leading-zero blanking, per-digit
// blink, decimal points and 8-level PWM brightness are supported.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   load        one-cycle strobe capturing bcd_in/dp_in/blink_mask into shadow
//   bcd_in      digit codes, digit 0 (rightmost) in [3:0]
//   dp_in       decimal point enable per digit (1 = lit)
//   blink_mask  per-digit blink enable
//   blank_lz    suppress leading zeros
//   bright      brightness 0 (dimmest) .. 7 (full)
//   an          anode selects, active-low
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   frame_done  one-cycle pulse at each frame start

module fnd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    input  logic [2:0]              bright,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int SLOT8 = SCAN_DIV / 8;

    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic [SW-1:0]           sel_q, sel_d;
    logic [FW-1:0]           fcnt_q, fcnt_d;
    logic                    blink_ph_q, blink_ph_d;

    logic [4*NUM_DIGITS-1:0] sh_bcd_q, sh_bcd_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
    logic [4*NUM_DIGITS-1:0] dsp_bcd_q, dsp_bcd_d;
    logic [NUM_DIGITS-1:0]   dsp_dp_q, dsp_dp_d;
    logic [NUM_DIGITS-1:0]   dsp_blink_q, dsp_blink_d;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tick;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    lz_run;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    cur_lz;
    logic                    digit_off;
    logic [31:0]             on_limit;

    assign tick = (pcnt_q == PW'(SCAN_DIV - 1));
    assign wrap = tick && (sel_q == SW'(NUM_DIGITS - 1));

    // Scan timing: prescaler, digit select and the frame counter that
    // paces the blink phase.
    always_comb begin
        pcnt_d     = tick ? '0 : pcnt_q + PW'(1);
        sel_d      = sel_q;
        fcnt_d     = fcnt_q;
        blink_ph_d = blink_ph_q;
        if (tick) begin
            sel_d = (sel_q == SW'(NUM_DIGITS - 1)) ? '0 : sel_q + SW'(1);
        end
        if (wrap) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d     = '0;
                blink_ph_d = ~blink_ph_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    // Shadow/display pair. The display only copies the shadow at the frame
    // wrap; a load on that same edge lands in the shadow and waits a frame.
    always_comb begin
        sh_bcd_d    = sh_bcd_q;
        sh_dp_d     = sh_dp_q;
        sh_blink_d  = sh_blink_q;
        dsp_bcd_d   = dsp_bcd_q;
        dsp_dp_d    = dsp_dp_q;
        dsp_blink_d = dsp_blink_q;
        if (load) begin
            sh_bcd_d   = bcd_in;
            sh_dp_d    = dp_in;
            sh_blink_d = blink_mask;
        end
        if (wrap) begin
            dsp_bcd_d   = sh_bcd_q;
            dsp_dp_d    = sh_dp_q;
            dsp_blink_d = sh_blink_q;
        end
    end

    // Leading-zero blanking walks down from the top digit; the first nonzero
    // code or lit decimal point ends the run. Digit 0 is never blanked.
    always_comb begin
        lz_blank = '0;
        lz_run   = blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (dsp_bcd_q[4*i +: 4] != 4'd0 || dsp_dp_q[i]) begin
                lz_run = 1'b0;
            end
            lz_blank[i] = lz_run;
        end
    end

    // Output stage: pick the current digit, decode it and gate the anode by
    // blanking and the PWM window inside the slot.
    always_comb begin
        cur_code  = 4'd0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q == SW'(i)) begin
                cur_code  = dsp_bcd_q[4*i +: 4];
                cur_dp    = dsp_dp_q[i];
                cur_blink = dsp_blink_q[i];
                cur_lz    = lz_blank[i];
            end
        end

        digit_off = cur_lz | (cur_blink & blink_ph_q);
        on_limit  = (32'(bright) + 32'd1) * 32'(SLOT8);

        an_d = '1;
        if (!digit_off && (32'(pcnt_q) < on_limit)) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_q == SW'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
        end

        case (cur_code)
            4'h0:    seg_d = 7'b1000000;
            4'h1:    seg_d = 7'b1111001;
            4'h2:    seg_d = 7'b0100100;
            4'h3:    seg_d = 7'b0110000;
            4'h4:    seg_d = 7'b0011001;
            4'h5:    seg_d = 7'b0010010;
            4'h6:    seg_d = 7'b0000010;
            4'h7:    seg_d = 7'b1111000;
            4'h8:    seg_d = 7'b0000000;
            4'h9:    seg_d = 7'b0010000;
            4'hF:    seg_d = 7'b0111111;
            default: seg_d = 7'b1111111;
        endcase

        dp_d         = ~(cur_dp & ~(cur_blink & blink_ph_q));
        frame_done_d = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q       <= '0;
            sel_q        <= '0;
            fcnt_q       <= '0;
            blink_ph_q   <= 1'b0;
            sh_bcd_q     <= '0;
            sh_dp_q      <= '0;
            sh_blink_q   <= '0;
            dsp_bcd_q    <= '0;
            dsp_dp_q     <= '0;
            dsp_blink_q  <= '0;
            an_q         <= '1;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            sel_q        <= sel_d;
            fcnt_q       <= fcnt_d;
            blink_ph_q   <= blink_ph_d;
            sh_bcd_q     <= sh_bcd_d;
            sh_dp_q      <= sh_dp_d;
            sh_blink_q   <= sh_blink_d;
            dsp_bcd_q    <= dsp_bcd_d;
            dsp_dp_q     <= dsp_dp_d;
            dsp_blink_q  <= dsp_blink_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl
// Directed bench for fnd_scan_ctrl with 4 digits, 16 clk per slot and a
// 2-frame blink half-period. Each frame is scanned slot by slot, counting the
// cycles each anode is low and checking the segment/dp pattern of the slot.

module tb_fnd_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 16;
    localparam int BF = 2;
    localparam int FRAME = ND * SD;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S5    = 7'b0010010;
    localparam logic [6:0] S9    = 7'b0010000;
    localparam logic [6:0] SMIN  = 7'b0111111;
    localparam logic [6:0] SBLK  = 7'b1111111;

    logic          clk;
    logic          rst;
    logic          load;
    logic [15:0]   bcd_in;
    logic [3:0]    dp_in;
    logic [3:0]    blink_mask;
    logic          blank_lz;
    logic [2:0]    bright;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_done;

    int            checkCount;
    int            errCount;
    int            edgeCount;
    int            fdEdges[$];

    fnd_scan_ctrl #(
        .NUM_DIGITS(ND),
        .SCAN_DIV(SD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .bcd_in(bcd_in),
        .dp_in(dp_in),
        .blink_mask(blink_mask),
        .blank_lz(blank_lz),
        .bright(bright),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_done(frame_done)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Number of active edges since reset was released.
    always @(posedge clk or posedge rst) begin
        if (rst) edgeCount <= 0;
        else     edgeCount <= edgeCount + 1;
    end

    // Remember when frame_done was seen high.
    always @(negedge clk) begin
        if (!rst && frame_done) fdEdges.push_back(edgeCount);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitEdge(input int k);
        while (edgeCount < k) @(negedge clk);
    endtask

    // Stage new data and strobe load for one cycle after edge atEdge.
    task automatic applyStimulus(input logic [15:0] bcd, input logic [3:0] dpv,
                                 input logic [3:0] mask, input int atEdge);
        waitEdge(atEdge);
        bcd_in     = bcd;
        dp_in      = dpv;
        blink_mask = mask;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    // Observe frame f: anode-on cycle count, seg and dp per digit slot,
    // plus any cycle where a wrong anode was driven low.
    task automatic scanFrame(input string tag, input int f, input logic [3:0] lit,
                             input logic [27:0] expSeg, input logic [3:0] expDp,
                             input int onCycles);
        int         lowCnt;
        int         stray;
        logic [6:0] segFirst;
        logic       dpFirst;
        logic [3:0] expAn;
        waitEdge(f * FRAME + 1);
        stray    = 0;
        segFirst = '0;
        dpFirst  = 1'b0;
        for (int d = 0; d < ND; d++) begin
            expAn  = ~(4'b0001 << d);
            lowCnt = 0;
            for (int c = 0; c < SD; c++) begin
                if (c == 0) begin
                    segFirst = seg;
                    dpFirst  = dp;
                end
                if (an == expAn) lowCnt++;
                else if (an != 4'hF) stray++;
                if (c != SD - 1) @(negedge clk);
            end
            checkOutput($sformatf("%s d%0d on", tag, d), lowCnt, lit[d] ? onCycles : 0);
            checkOutput($sformatf("%s d%0d seg", tag, d), {25'd0, segFirst}, {25'd0, expSeg[7*d +: 7]});
            checkOutput($sformatf("%s d%0d dp", tag, d), {31'd0, dpFirst}, {31'd0, expDp[d]});
            if (d != ND - 1) @(negedge clk);
        end
        checkOutput($sformatf("%s stray", tag), stray, 0);
    endtask

    initial begin
        checkCount = 0;
        errCount   = 0;
        rst        = 1'b1;
        load       = 1'b0;
        bcd_in     = '0;
        dp_in      = '0;
        blink_mask = '0;
        blank_lz   = 1'b0;
        bright     = 3'd7;

        repeat (3) @(negedge clk);
        checkOutput("rst an", {28'd0, an}, 32'hF);
        checkOutput("rst seg", {25'd0, seg}, 32'h7F);
        checkOutput("rst dp", {31'd0, dp}, 32'd1);
        checkOutput("rst fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        fork
            scanFrame("f0", 0, 4'b1111, {S0, S0, S0, S0}, 4'hF, 16);
            applyStimulus(16'h1234, 4'b0000, 4'b0000, 30);
        join
        blank_lz = 1'b1;
        fork
            scanFrame("f1", 1, 4'b1111, {S1, S2, S3, S4}, 4'hF, 16);
            applyStimulus(16'h0050, 4'b0000, 4'b0000, FRAME + 30);
        join
        fork
            scanFrame("lz", 2, 4'b0011, {S0, S0, S5, S0}, 4'hF, 16);
            applyStimulus(16'h0050, 4'b0100, 4'b0000, 2 * FRAME + 30);
        join
        fork
            scanFrame("lzdp", 3, 4'b0111, {S0, S0, S5, S0}, 4'b1011, 16);
            applyStimulus(16'h0050, 4'b0000, 4'b0001, 3 * FRAME + 40);
        join
        checkOutput("fd first", fdEdges[0], 64);
        checkOutput("fd second", fdEdges[1], 128);
        checkOutput("fd third", fdEdges[2], 192);

        scanFrame("blink4", 4, 4'b0011, {S0, S0, S5, S0}, 4'hF, 16);
        scanFrame("blink5", 5, 4'b0011, {S0, S0, S5, S0}, 4'hF, 16);
        scanFrame("blink6", 6, 4'b0010, {S0, S0, S5, S0}, 4'hF, 16);
        scanFrame("blink7", 7, 4'b0010, {S0, S0, S5, S0}, 4'hF, 16);
        fork
            scanFrame("blink8", 8, 4'b0011, {S0, S0, S5, S0}, 4'hF, 16);
            applyStimulus(16'h0050, 4'b0000, 4'b0000, 8 * FRAME + 30);
        join

        bright = 3'd0;
        scanFrame("br0", 9, 4'b0011, {S0, S0, S5, S0}, 4'hF, 2);
        bright = 3'd3;
        scanFrame("br3", 10, 4'b0011, {S0, S0, S5, S0}, 4'hF, 8);
        bright = 3'd7;
        fork
            scanFrame("br7", 11, 4'b0011, {S0, S0, S5, S0}, 4'hF, 16);
            applyStimulus(16'hFA09, 4'b0000, 4'b0000, 11 * FRAME + 30);
        join
        scanFrame("fa09", 12, 4'b1111, {SMIN, SBLK, S0, S9}, 4'hF, 16);

        waitEdge(13 * FRAME + 20);
        rst = 1'b1;
        #1;
        checkOutput("midrst an", {28'd0, an}, 32'hF);
        checkOutput("midrst seg", {25'd0, seg}, 32'h7F);
        checkOutput("midrst dp", {31'd0, dp}, 32'd1);
        checkOutput("midrst fd", {31'd0, frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        scanFrame("post", 0, 4'b0001, {S0, S0, S0, S0}, 4'hF, 16);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
